// File: rtl/rsm_pkg.sv
`default_nettype none
// ============================================================================
// rsm_pkg : shared encodings for the simple RISC machine front end
// Rev 1.0
// ============================================================================
package rsm_pkg;

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [1:0] OPX_IMM = 2'b10;
    localparam logic [1:0] OPX_REG = 2'b00;

    localparam logic [2:0] NSEL_RN = 3'b100;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b001;

    localparam int INSTR_W  = 16;
    localparam int OPC_LSB  = 13;
    localparam int OPX_LSB  = 11;
    localparam int RN_LSB   = 8;
    localparam int RD_LSB   = 5;
    localparam int SH_LSB   = 3;
    localparam int RM_LSB   = 0;
    localparam int IMM8_MSB = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } issue_state_t;

    function automatic logic is_legal(input logic [INSTR_W-1:0] instr);
        logic [2:0] opc;
        logic [1:0] opx;
        opc = instr[OPC_LSB +: 3];
        opx = instr[OPX_LSB +: 2];
        return (opc == OP_ALU) ||
               ((opc == OP_MOV) && ((opx == OPX_IMM) || (opx == OPX_REG)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_issue_if.sv
`default_nettype none
// ============================================================================
// instr_issue_if : loader, controller handshake and decoded-field bundle
// Rev 1.0
// ============================================================================
interface instr_issue_if #(
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_instr;
    logic          w;
    logic [2:0]    nsel;
    logic          s;
    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [1:0]    shift;
    logic [15:0]   sximm8;
    logic [2:0]    readnum;
    logic [2:0]    writenum;
    logic          busy;
    logic          err;
    logic [CW-1:0] retired;

    modport master (
        input  in_valid, in_instr, w, nsel,
        output in_ready, s, opcode, op, shift, sximm8,
               readnum, writenum, busy, err, retired
    );

    modport slave (
        output in_valid, in_instr, w, nsel,
        input  in_ready, s, opcode, op, shift, sximm8,
               readnum, writenum, busy, err, retired
    );
endinterface
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// instr_fifo : power-of-two circular instruction queue with occupancy count
// Rev 1.0
// ============================================================================
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (!push && pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == FULL_COUNT);
    assign empty = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/vDFF.sv
`default_nettype none
// ============================================================================
// vDFF : plain N-bit rising-edge register, no reset
// Rev 1.0
// ============================================================================
module vDFF #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);
    always_ff @(posedge clk) begin
        Q <= D;
    end
endmodule
`default_nettype wire

// File: rtl/instr_issue.sv
`default_nettype none
// ============================================================================
// instr_issue : queues instructions, decodes IR and issues via the s/w handshake
// Rev 1.0
// ============================================================================
module instr_issue
    import rsm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    instr_issue_if.master      bus
);
    localparam int                 AW        = $clog2(DEPTH);
    localparam logic [AW:0]        CNT_FULL  = (AW+1)'(DEPTH);

    logic [15:0]   w_head;
    logic [AW:0]   w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_retire;
    logic          w_err;
    logic          w_head_ok;
    logic [1:0]    w_state_bits;
    issue_state_t  w_state;
    issue_state_t  w_state_next;
    logic [15:0]   r_ir;
    logic [CW-1:0] r_retired;

    assign w_push      = bus.in_valid && !w_full;
    assign bus.in_ready = (w_count != CNT_FULL);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.in_instr),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_head_ok = is_legal(w_head);

    vDFF #(.N(2)) u_state (
        .clk (clk),
        .D   (w_state_next),
        .Q   (w_state_bits)
    );
    assign w_state = issue_state_t'(w_state_bits);

    always_comb begin
        w_state_next = w_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_retire     = 1'b0;
        w_err        = 1'b0;
        if (reset) begin
            w_state_next = ST_IDLE;
        end else begin
            case (w_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head_ok) begin
                            w_load       = 1'b1;
                            w_state_next = ST_START;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (bus.w) begin
                        w_state_next = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Retire and chain straight into the next legal head: no IDLE bubble.
                    if (bus.w) begin
                        w_retire = 1'b1;
                        if (!w_empty && w_head_ok) begin
                            w_pop        = 1'b1;
                            w_load       = 1'b1;
                            w_state_next = ST_START;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            if (w_load) begin
                r_ir <= w_head;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign bus.s       = (w_state == ST_START) && bus.w;
    assign bus.busy    = (w_state != ST_IDLE);
    assign bus.err     = w_err;
    assign bus.retired = r_retired;

    assign bus.opcode  = r_ir[OPC_LSB +: 3];
    assign bus.op      = r_ir[OPX_LSB +: 2];
    assign bus.shift   = r_ir[SH_LSB +: 2];
    assign bus.sximm8  = {{8{r_ir[IMM8_MSB]}}, r_ir[IMM8_MSB:0]};

    always_comb begin
        bus.readnum = 3'd0;
        case (bus.nsel)
            NSEL_RN: bus.readnum = r_ir[RN_LSB +: 3];
            NSEL_RD: bus.readnum = r_ir[RD_LSB +: 3];
            NSEL_RM: bus.readnum = r_ir[RM_LSB +: 3];
            default: bus.readnum = 3'd0;
        endcase
    end
    assign bus.writenum = bus.readnum;
endmodule
`default_nettype wire

// File: tb/tb_instr_issue.sv
`default_nettype none
// ============================================================================
// tb_instr_issue : randomized issue bench with a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_instr_issue;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_issue_if #(.CW(8)) bus ();

    instr_issue #(.DEPTH(4), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int tick_no = 0;

    logic [15:0] src[$];
    logic [15:0] acc[$];
    int          acc_ticks[$];
    logic [22:0] obs_f[$];
    logic [2:0]  obs_rn[$];
    logic [2:0]  obs_ns[$];
    int          s_ticks[$];
    int          wrise[$];
    int          err_cnt, s_bad, unstable;
    logic [22:0] last_f;
    bit          ctrl_auto, ctrl_working, nsel_rand;
    int          busy_min, busy_max, busy_cnt, valid_pct;
    logic        prev_w, s_now;

    // ---------------- reference model (specification-level) ----------------
    function automatic bit ref_legal(input logic [15:0] wd);
        int v, opc, opx;
        v   = int'(wd);
        opc = v >> 13;
        opx = (v >> 11) & 3;
        return (opc == 5) || (opc == 6 && (opx == 2 || opx == 0));
    endfunction

    function automatic logic [22:0] ref_fields(input logic [15:0] wd);
        int v, imm;
        v   = int'(wd);
        imm = v & 255;
        if (imm >= 128) imm = imm + 65280;
        return {3'((v >> 13) & 7), 2'((v >> 11) & 3), 2'((v >> 3) & 3), 16'(imm)};
    endfunction

    function automatic logic [2:0] ref_readnum(input logic [15:0] wd, input logic [2:0] ns);
        int v;
        v = int'(wd);
        if (ns == 3'b100) return 3'((v >> 8) & 7);
        if (ns == 3'b010) return 3'((v >> 5) & 7);
        if (ns == 3'b001) return 3'(v & 7);
        return 3'd0;
    endfunction

    function automatic logic [15:0] rand_legal();
        logic [15:0] wd;
        wd = 16'($urandom);
        case ($urandom_range(2, 0))
            0:       wd[15:11] = 5'b110_10;
            1:       wd[15:11] = 5'b110_00;
            default: wd[15:13] = 3'b101;
        endcase
        return wd;
    endfunction

    // ---------------- clocking, loader and controller models ----------------
    task automatic tick();
        @(negedge clk);
        tick_no++;
        s_now = bus.s;
        if (bus.w && !prev_w) wrise.push_back(tick_no);
        prev_w = bus.w;
        if (bus.s) begin
            last_f = {bus.opcode, bus.op, bus.shift, bus.sximm8};
            obs_f.push_back(last_f);
            obs_rn.push_back(bus.readnum);
            obs_ns.push_back(bus.nsel);
            s_ticks.push_back(tick_no);
            if (!bus.w) s_bad++;
        end
        if (bus.err) err_cnt++;
        if (ctrl_working && !bus.s && ({bus.opcode, bus.op, bus.shift, bus.sximm8} != last_f))
            unstable++;
        if (bus.in_valid && bus.in_ready) begin
            acc.push_back(bus.in_instr);
            acc_ticks.push_back(tick_no);
            void'(src.pop_front());
        end
        @(posedge clk);
        #1;
        if (ctrl_auto) begin
            if (s_now) begin
                ctrl_working = 1'b1;
                busy_cnt     = $urandom_range(busy_max, busy_min);
                bus.w        = 1'b0;
            end else if (ctrl_working) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    ctrl_working = 1'b0;
                    bus.w        = 1'b1;
                end
            end
        end
        if (src.size() > 0 && $urandom_range(99, 0) < valid_pct) begin
            bus.in_valid = 1'b1;
            bus.in_instr = src[0];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_instr = 16'($urandom);
        end
        if (nsel_rand) begin
            case ($urandom_range(3, 0))
                0:       bus.nsel = 3'b100;
                1:       bus.nsel = 3'b010;
                2:       bus.nsel = 3'b001;
                default: bus.nsel = 3'($urandom_range(7, 0));
            endcase
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_instr = 16'h0000;
        bus.w        = 1'b1;
        bus.nsel     = 3'b100;
        ctrl_auto    = 1'b1;
        ctrl_working = 1'b0;
        nsel_rand    = 1'b0;
        busy_min     = 1;
        busy_max     = 3;
        valid_pct    = 100;
        src.delete(); acc.delete(); acc_ticks.delete();
        obs_f.delete(); obs_rn.delete(); obs_ns.delete();
        s_ticks.delete(); wrise.delete();
        err_cnt = 0; s_bad = 0; unstable = 0; last_f = '0;
        prev_w  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (src.size() == 0 && (obs_f.size() + err_cnt) == acc.size() &&
                !ctrl_working && bus.w && !bus.busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        tick();
        total++; if (bus.s !== 1'b0)        begin bad++; $display("FAIL reset_s: got %b want 0", bus.s); end
        total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.err !== 1'b0)      begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        total++; if (bus.retired !== 8'd0)  begin bad++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if ({bus.opcode, bus.op, bus.shift, bus.sximm8} !== 23'd0)
            begin bad++; $display("FAIL reset_ir: got %h want 0", {bus.opcode, bus.op, bus.shift, bus.sximm8}); end
    endtask

    task automatic test_mov_imm();
        bit ok;
        do_reset();
        busy_min = 2; busy_max = 2;
        src.push_back(16'hD305);
        drain(60, ok);
        total++; if (!ok) begin bad++; $display("FAIL mov_drain: got timeout want drained"); end
        total++; if (s_ticks.size() != 1) begin bad++; $display("FAIL mov_s_count: got %0d want 1", s_ticks.size()); end
        if (s_ticks.size() == 1 && acc_ticks.size() == 1) begin
            total++; if (s_ticks[0] - acc_ticks[0] != 2)
                begin bad++; $display("FAIL mov_latency: got %0d want 2", s_ticks[0] - acc_ticks[0]); end
            total++; if (obs_rn[0] !== 3'd3) begin bad++; $display("FAIL mov_readnum: got %0d want 3", obs_rn[0]); end
            total++; if (obs_f[0][15:0] !== 16'h0005) begin bad++; $display("FAIL mov_sximm8: got %h want 0005", obs_f[0][15:0]); end
        end
        total++; if (bus.retired !== 8'd1) begin bad++; $display("FAIL mov_retired: got %0d want 1", bus.retired); end
        total++; if (s_bad != 0) begin bad++; $display("FAIL mov_s_without_w: got %0d want 0", s_bad); end
    endtask

    task automatic test_fields();
        bit ok;
        logic [15:0] sx;
        do_reset();
        busy_min = 6; busy_max = 6;
        src.push_back(16'hD2F8);
        src.push_back(16'hA16A);
        for (int i = 0; i < 60 && obs_f.size() < 2; i++) tick();
        total++; if (obs_f.size() != 2) begin bad++; $display("FAIL fields_issue: got %0d want 2", obs_f.size()); end
        if (obs_f.size() >= 1) begin
            sx = obs_f[0][15:0];
            total++; if (sx !== 16'hFFF8) begin bad++; $display("FAIL fields_sximm8_neg: got %h want FFF8", sx); end
        end
        total++; if (bus.shift !== 2'b01) begin bad++; $display("FAIL fields_shift: got %b want 01", bus.shift); end
        bus.nsel = 3'b001; tick();
        total++; if (bus.readnum !== 3'd2) begin bad++; $display("FAIL fields_rm: got %0d want 2", bus.readnum); end
        bus.nsel = 3'b100; tick();
        total++; if (bus.readnum !== 3'd1) begin bad++; $display("FAIL fields_rn: got %0d want 1", bus.readnum); end
        bus.nsel = 3'b010; tick();
        total++; if (bus.readnum !== 3'd3 || bus.writenum !== 3'd3)
            begin bad++; $display("FAIL fields_rd: got %0d/%0d want 3/3", bus.readnum, bus.writenum); end
        bus.nsel = 3'b011; tick();
        total++; if (bus.readnum !== 3'd0) begin bad++; $display("FAIL fields_bad_nsel: got %0d want 0", bus.readnum); end
        drain(60, ok);
        total++; if (!ok || bus.retired !== 8'd2)
            begin bad++; $display("FAIL fields_retired: got %0d ok=%0d want 2", bus.retired, ok); end
    endtask

    task automatic test_illegal();
        bit ok;
        do_reset();
        src.push_back(16'hE000);
        src.push_back(16'hC04A);
        drain(60, ok);
        total++; if (!ok) begin bad++; $display("FAIL illegal_drain: got timeout want drained"); end
        total++; if (err_cnt != 1) begin bad++; $display("FAIL illegal_err_cycles: got %0d want 1", err_cnt); end
        total++; if (obs_f.size() != 1) begin bad++; $display("FAIL illegal_s_count: got %0d want 1", obs_f.size()); end
        if (obs_f.size() == 1) begin
            total++; if (obs_f[0] !== ref_fields(16'hC04A))
                begin bad++; $display("FAIL illegal_issued: got %h want %h", obs_f[0], ref_fields(16'hC04A)); end
        end
        total++; if (bus.retired !== 8'd1) begin bad++; $display("FAIL illegal_retired: got %0d want 1", bus.retired); end
    endtask

    task automatic test_fill_b2b();
        bit ok, found;
        do_reset();
        ctrl_auto = 1'b0;
        bus.w     = 1'b0;
        for (int i = 0; i < 6; i++) src.push_back(rand_legal());
        for (int i = 0; i < 30 && acc.size() < 5; i++) tick();
        tick();
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %b want 0", bus.in_ready); end
        total++; if (acc.size() != 5) begin bad++; $display("FAIL fill_accepted: got %0d want 5", acc.size()); end
        total++; if (obs_f.size() != 0 || bus.s !== 1'b0)
            begin bad++; $display("FAIL fill_stalled_s: got %0d pulses want 0", obs_f.size()); end
        ctrl_auto = 1'b1;
        bus.w     = 1'b1;
        busy_min  = 1; busy_max = 3;
        drain(200, ok);
        total++; if (!ok || obs_f.size() != 6)
            begin bad++; $display("FAIL fill_issued: got %0d ok=%0d want 6", obs_f.size(), ok); end
        for (int i = 0; i < obs_f.size() && i < acc.size(); i++) begin
            total++; if (obs_f[i] !== ref_fields(acc[i]))
                begin bad++; $display("FAIL fill_order[%0d]: got %h want %h", i, obs_f[i], ref_fields(acc[i])); end
        end
        for (int i = 1; i < s_ticks.size(); i++) begin
            found = 1'b0;
            foreach (wrise[j]) if (wrise[j] == s_ticks[i] - 1) found = 1'b1;
            total++; if (!found) begin bad++; $display("FAIL fill_bubble[%0d]: got s at %0d want one after w rise", i, s_ticks[i]); end
        end
        total++; if (bus.retired !== 8'd6) begin bad++; $display("FAIL fill_retired: got %0d want 6", bus.retired); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        busy_min = 8; busy_max = 8;
        for (int i = 0; i < 3; i++) src.push_back(rand_legal());
        for (int i = 0; i < 40 && !(obs_f.size() == 1 && acc.size() == 3); i++) tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_pre_busy: got %b want 1", bus.busy); end
        reset = 1'b1;
        src.delete();
        bus.in_valid = 1'b0;
        ctrl_working = 1'b0;
        bus.w = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.s !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
            begin bad++; $display("FAIL rmid_flush: got s=%b busy=%b rdy=%b want 0 0 1", bus.s, bus.busy, bus.in_ready); end
        total++; if (bus.opcode !== 3'd0 || bus.sximm8 !== 16'd0)
            begin bad++; $display("FAIL rmid_ir: got %h/%h want 0/0", bus.opcode, bus.sximm8); end
        for (int i = 0; i < 15; i++) tick();
        total++; if (obs_f.size() != 1 || err_cnt != 0)
            begin bad++; $display("FAIL rmid_no_issue: got %0d pulses %0d err want 1 0", obs_f.size(), err_cnt); end
    endtask

    task automatic test_hold_start();
        bit ok;
        do_reset();
        ctrl_auto = 1'b0;
        bus.w     = 1'b0;
        src.push_back(16'hD305);
        for (int i = 0; i < 6; i++) tick();
        total++; if (obs_f.size() != 0 || bus.busy !== 1'b1)
            begin bad++; $display("FAIL hold_pending: got %0d pulses busy=%b want 0 1", obs_f.size(), bus.busy); end
        ctrl_auto = 1'b1;
        bus.w     = 1'b1;
        drain(40, ok);
        total++; if (!ok || obs_f.size() != 1 || s_bad != 0)
            begin bad++; $display("FAIL hold_release: got %0d pulses bad_s=%0d want 1 0", obs_f.size(), s_bad); end
    endtask

    task automatic test_random();
        bit ok;
        int n_legal, n_illegal, k;
        do_reset();
        busy_min = 1; busy_max = 4;
        nsel_rand = 1'b1;
        valid_pct = 60;
        for (int i = 0; i < 120; i++)
            src.push_back(($urandom_range(99, 0) < 30) ? 16'($urandom) : rand_legal());
        drain(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_drain: got timeout want drained"); end
        n_legal = 0; n_illegal = 0; k = 0;
        foreach (acc[i]) begin
            if (!ref_legal(acc[i])) begin
                n_illegal++;
            end else begin
                n_legal++;
                if (k < obs_f.size()) begin
                    total++; if (obs_f[k] !== ref_fields(acc[i]) || obs_rn[k] !== ref_readnum(acc[i], obs_ns[k]))
                        begin bad++; $display("FAIL rand_issue[%0d]: got %h/%0d want %h/%0d", k, obs_f[k], obs_rn[k],
                                              ref_fields(acc[i]), ref_readnum(acc[i], obs_ns[k])); end
                end
                k++;
            end
        end
        total++; if (obs_f.size() != n_legal) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_f.size(), n_legal); end
        total++; if (err_cnt != n_illegal) begin bad++; $display("FAIL rand_err: got %0d want %0d", err_cnt, n_illegal); end
        total++; if (bus.retired !== 8'(n_legal)) begin bad++; $display("FAIL rand_retired: got %0d want %0d", bus.retired, n_legal % 256); end
        total++; if (s_bad != 0) begin bad++; $display("FAIL rand_s_without_w: got %0d want 0", s_bad); end
        total++; if (unstable != 0) begin bad++; $display("FAIL rand_ir_stable: got %0d changes want 0", unstable); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        busy_min = 1; busy_max = 1;
        for (int i = 0; i < 260; i++) src.push_back(rand_legal());
        drain(4000, ok);
        total++; if (!ok || obs_f.size() != 260)
            begin bad++; $display("FAIL wrap_issued: got %0d ok=%0d want 260", obs_f.size(), ok); end
        total++; if (bus.retired !== 8'd4) begin bad++; $display("FAIL wrap_retired: got %0d want 4", bus.retired); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mov_imm();
        test_fields();
        test_illegal();
        test_fill_b2b();
        test_reset_mid();
        test_hold_start();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
